// File: rtl/led_matrix_pkg.sv
// Shared constants for the LED-matrix data path: FSM encoding, default geometry and the
// position of each colour channel inside a framebuffer pixel word.
package led_matrix_pkg;

   localparam int unsigned COLOR_BITS_DEF = 7;
   localparam int unsigned COLUMNS_DEF    = 64;

   // Line shifter FSM encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_READ     = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Channel slot index inside a pixel word {R,G,B}; bit offset is slot * COLOR_BITS
   localparam int unsigned R_FIELD = 2;
   localparam int unsigned G_FIELD = 1;
   localparam int unsigned B_FIELD = 0;

endpackage

// File: rtl/led_pwm_compare.sv
// Thresholds one {R,G,B} pixel against the current PWM value; a channel is lit when it is
// strictly greater than the threshold, so channel 0 is always dark.
module led_pwm_compare
   import led_matrix_pkg::*;
#(
   parameter int unsigned COLOR_BITS = COLOR_BITS_DEF
) (
   input  logic [3*COLOR_BITS-1:0] i_pixel,
   input  logic [COLOR_BITS-1:0]   i_pwm,
   output logic [2:0]              o_rgb
);

   // Unsigned strict compare per channel, output ordered {R,G,B}
   always_comb begin
      o_rgb    = 3'b000;
      o_rgb[2] = i_pixel[R_FIELD*COLOR_BITS +: COLOR_BITS] > i_pwm;
      o_rgb[1] = i_pixel[G_FIELD*COLOR_BITS +: COLOR_BITS] > i_pwm;
      o_rgb[0] = i_pixel[B_FIELD*COLOR_BITS +: COLOR_BITS] > i_pwm;
   end

endmodule

// File: rtl/led_line_shifter.sv
// Shifts one double-row of PWM-thresholded pixels into the HUB75 shift registers.
// Each column takes three cycles: READ (address presented), SHIFT_LO (framebuffer data
// valid, bits registered), SHIFT_HI (sclk rises). fb_addr is updated on entry to READ so
// the synchronous framebuffer read lands in SHIFT_LO.
module led_line_shifter
   import led_matrix_pkg::*;
#(
   parameter int unsigned COLUMNS    = COLUMNS_DEF,
   parameter int unsigned COLOR_BITS = COLOR_BITS_DEF,
   parameter int unsigned ROW_BITS   = 5,
   parameter int unsigned AUTOSTART  = 1
) (
   input  logic                                  clk_25MHz,
   input  logic                                  rst,
   input  logic                                  next_line_begin,
   input  logic [ROW_BITS-1:0]                   next_line_addr,
   input  logic [COLOR_BITS-1:0]                 next_line_pwm,
   output logic                                  next_line_done,
   output logic [ROW_BITS+$clog2(COLUMNS)-1:0]   fb_addr,
   input  logic [3*COLOR_BITS-1:0]               fb_data_top,
   input  logic [3*COLOR_BITS-1:0]               fb_data_bot,
   output logic [2:0]                            rgb_top,
   output logic [2:0]                            rgb_bot,
   output logic                                  sclk
);

   localparam int unsigned          COL_BITS = $clog2(COLUMNS);
   localparam logic [COL_BITS-1:0]  LAST_COL = COL_BITS'(COLUMNS - 1);
   localparam logic [2:0]           RST_STATE = (AUTOSTART != 0) ? ST_READ : ST_IDLE;

   logic [2:0]                  r_state;
   logic [COL_BITS-1:0]         r_col;
   logic [ROW_BITS-1:0]         r_row;
   logic [COLOR_BITS-1:0]       r_pwm;
   logic [ROW_BITS+COL_BITS-1:0] r_fb_addr;
   logic [2:0]                  r_rgb_top;
   logic [2:0]                  r_rgb_bot;
   logic                        r_sclk;
   logic                        r_done;

   logic [2:0]                  w_rgb_top;
   logic [2:0]                  w_rgb_bot;

   led_pwm_compare #(
      .COLOR_BITS (COLOR_BITS)
   ) u_cmp_top (
      .i_pixel (fb_data_top),
      .i_pwm   (r_pwm),
      .o_rgb   (w_rgb_top)
   );

   led_pwm_compare #(
      .COLOR_BITS (COLOR_BITS)
   ) u_cmp_bot (
      .i_pixel (fb_data_bot),
      .i_pwm   (r_pwm),
      .o_rgb   (w_rgb_bot)
   );

   // Line sequencer; every output is a register updated here
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         r_state   <= RST_STATE;
         r_col     <= '0;
         r_row     <= '0;
         r_pwm     <= '0;
         r_fb_addr <= '0;
         r_rgb_top <= 3'b000;
         r_rgb_bot <= 3'b000;
         r_sclk    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (next_line_begin) begin
                  r_row     <= next_line_addr;
                  r_pwm     <= next_line_pwm;
                  r_col     <= '0;
                  r_fb_addr <= {next_line_addr, {COL_BITS{1'b0}}};
                  r_state   <= ST_READ;
               end
            end
            ST_READ: begin
               r_fb_addr <= {r_row, r_col};
               r_sclk    <= 1'b0;
               r_state   <= ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
               r_rgb_top <= w_rgb_top;
               r_rgb_bot <= w_rgb_bot;
               r_sclk    <= 1'b0;
               r_state   <= ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
               r_sclk <= 1'b1;
               if (r_col == LAST_COL) begin
                  r_state <= ST_DONE;
               end else begin
                  // Present the next address now so it is valid throughout READ
                  r_col     <= r_col + 1'b1;
                  r_fb_addr <= {r_row, r_col + 1'b1};
                  r_state   <= ST_READ;
               end
            end
            ST_DONE: begin
               r_done    <= 1'b1;
               r_sclk    <= 1'b0;
               r_rgb_top <= 3'b000;
               r_rgb_bot <= 3'b000;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign next_line_done = r_done;
   assign fb_addr        = r_fb_addr;
   assign rgb_top        = r_rgb_top;
   assign rgb_bot        = r_rgb_bot;
   assign sclk           = r_sclk;

endmodule

// File: tb/tb_led_line_shifter.sv
// Directed bench for led_line_shifter with a behavioural synchronous framebuffer.
module tb_led_line_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        nl_begin;
   logic [4:0]  nl_addr;
   logic [6:0]  nl_pwm;
   logic        nl_done;
   logic [10:0] fb_addr;
   logic [20:0] fb_data_top = '0;
   logic [20:0] fb_data_bot = '0;
   logic [2:0]  rgb_top;
   logic [2:0]  rgb_bot;
   logic        sclk;

   logic [20:0] mem_top [0:2047];
   logic [20:0] mem_bot [0:2047];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Monitor state: events are logged with the cycle number they were visible in
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc [0:63];
   int          rise_cnt = 0;
   logic [2:0]  rise_top [0:4095];
   logic [2:0]  rise_bot [0:4095];
   int          addr_cnt = 0;
   logic [10:0] addr_log [0:4095];
   logic        prev_sclk = 1'b0;
   logic [10:0] prev_addr = 'x;

   led_line_shifter #(
      .COLUMNS    (64),
      .COLOR_BITS (7),
      .ROW_BITS   (5),
      .AUTOSTART  (1)
   ) dut (
      .clk_25MHz       (clk),
      .rst             (rst),
      .next_line_begin (nl_begin),
      .next_line_addr  (nl_addr),
      .next_line_pwm   (nl_pwm),
      .next_line_done  (nl_done),
      .fb_addr         (fb_addr),
      .fb_data_top     (fb_data_top),
      .fb_data_bot     (fb_data_bot),
      .rgb_top         (rgb_top),
      .rgb_bot         (rgb_bot),
      .sclk            (sclk)
   );

   always #20 clk = ~clk;

   // Framebuffer: synchronous read, data valid one cycle after the address
   always @(posedge clk) begin
      fb_data_top <= mem_top[fb_addr];
      fb_data_bot <= mem_bot[fb_addr];
   end

   // Samples the values of the cycle that this edge closes
   always @(posedge clk) begin
      if (nl_done === 1'b1) begin
         done_cyc[done_cnt] = cyc;
         done_cnt++;
      end
      if (sclk === 1'b1 && prev_sclk !== 1'b1) begin
         rise_top[rise_cnt] = rgb_top;
         rise_bot[rise_cnt] = rgb_bot;
         rise_cnt++;
      end
      prev_sclk = sclk;
      if (fb_addr !== prev_addr) begin
         addr_log[addr_cnt] = fb_addr;
         addr_cnt++;
      end
      prev_addr = fb_addr;
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int base, input int budget, output int d);
      int n = 0;
      while (done_cnt <= base && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt > base) d = done_cyc[base];
      else begin
         d = -1;
         check("done_timeout", done_cnt, base + 1);
      end
   endtask

   task automatic run_line(input logic [4:0] a, input logic [6:0] p, output int t, output int d);
      int base;
      @(negedge clk);
      base     = done_cnt;
      nl_begin = 1'b1;
      nl_addr  = a;
      nl_pwm   = p;
      t        = cyc;
      @(negedge clk);
      nl_begin = 1'b0;
      wait_done(base, 400, d);
   endtask

   task automatic check_addr_seq(input string tag, input int ab, input logic [4:0] row);
      int bad = 0;
      logic [10:0] e;
      for (int i = 0; i < 64; i++) begin
         e = {row, 6'(i)};
         if (addr_log[ab + i] !== e) bad++;
      end
      check(tag, bad, 0);
   endtask

   initial begin
      int rel, d, t, rb, ab, base, nz, n;

      for (int i = 0; i < 2048; i++) begin
         mem_top[i] = '0;
         mem_bot[i] = '0;
      end
      rst      = 1'b1;
      nl_begin = 1'b0;
      nl_addr  = '0;
      nl_pwm   = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_done", {31'd0, nl_done}, 0);
      check("rst_sclk", {31'd0, sclk}, 0);
      check("rst_rgb_top", {29'd0, rgb_top}, 0);
      check("rst_rgb_bot", {29'd0, rgb_bot}, 0);
      check("rst_fb_addr", {21'd0, fb_addr}, 0);

      // Autostart line against an all-zero framebuffer
      rel  = cyc;
      base = done_cnt;
      rb   = rise_cnt;
      rst  = 1'b0;
      wait_done(base, 400, d);
      check("auto_latency", d - rel, 193);
      check("auto_rises", rise_cnt - rb, 64);
      nz = 0;
      for (int i = 0; i < 64; i++) if (rise_top[rb + i] != 0 || rise_bot[rb + i] != 0) nz++;
      check("auto_rgb_zero", nz, 0);
      check("done_width", {31'd0, nl_done}, 0);
      repeat (30) @(negedge clk);
      check("auto_single_done", done_cnt, base + 1);
      check("idle_no_sclk", rise_cnt - rb, 64);

      // Threshold patterns at row 3
      mem_top[{5'd3, 6'd10}] = {7'd100, 7'd0, 7'd0};
      mem_bot[{5'd3, 6'd10}] = {7'd0, 7'd0, 7'd5};
      mem_top[{5'd3, 6'd20}] = {7'd127, 7'd127, 7'd127};

      rb = rise_cnt;
      run_line(5'd3, 7'd4, t, d);
      check("pwm4_latency", d - t, 194);
      check("pwm4_top10", {29'd0, rise_top[rb + 10]}, 3'b100);
      check("pwm4_bot10", {29'd0, rise_bot[rb + 10]}, 3'b001);
      check("pwm4_top11", {29'd0, rise_top[rb + 11]}, 3'b000);
      check("pwm4_top20", {29'd0, rise_top[rb + 20]}, 3'b111);

      rb = rise_cnt;
      run_line(5'd3, 7'd5, t, d);
      check("pwm5_top10", {29'd0, rise_top[rb + 10]}, 3'b100);
      check("pwm5_bot10", {29'd0, rise_bot[rb + 10]}, 3'b000);

      rb = rise_cnt;
      run_line(5'd3, 7'd100, t, d);
      check("pwm100_top10", {29'd0, rise_top[rb + 10]}, 3'b000);
      check("pwm100_top20", {29'd0, rise_top[rb + 20]}, 3'b111);

      rb = rise_cnt;
      run_line(5'd3, 7'd126, t, d);
      check("pwm126_top20", {29'd0, rise_top[rb + 20]}, 3'b111);

      rb = rise_cnt;
      run_line(5'd3, 7'd127, t, d);
      check("pwm127_top20", {29'd0, rise_top[rb + 20]}, 3'b000);
      check("rgb_clear_after_done", {26'd0, rgb_top, rgb_bot}, 0);

      // Address sequence for row 7
      ab = addr_cnt;
      run_line(5'd7, 7'd0, t, d);
      check("row7_reads", addr_cnt - ab, 64);
      check_addr_seq("row7_addr_seq", ab, 5'd7);

      // Second begin in the middle of a line is ignored
      @(negedge clk);
      base     = done_cnt;
      rb       = rise_cnt;
      ab       = addr_cnt;
      nl_begin = 1'b1;
      nl_addr  = 5'd9;
      nl_pwm   = 7'd0;
      t        = cyc;
      @(negedge clk);
      nl_begin = 1'b0;
      repeat (49) @(negedge clk);
      nl_begin = 1'b1;
      nl_addr  = 5'd2;
      @(negedge clk);
      nl_begin = 1'b0;
      wait_done(base, 400, d);
      check("mid_begin_latency", d - t, 194);
      check("mid_begin_rises", rise_cnt - rb, 64);
      check_addr_seq("mid_begin_addr_seq", ab, 5'd9);
      repeat (30) @(negedge clk);
      check("mid_begin_single_done", done_cnt, base + 1);

      // Reset while shifting column 30
      @(negedge clk);
      base     = done_cnt;
      nl_begin = 1'b1;
      nl_addr  = 5'd5;
      nl_pwm   = 7'd0;
      @(negedge clk);
      nl_begin = 1'b0;
      n = 0;
      while (fb_addr !== {5'd5, 6'd30} && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_col30", {21'd0, fb_addr}, {21'd0, 5'd5, 6'd30});
      mem_top[0] = {7'd9, 7'd9, 7'd9};
      mem_top[0] = '0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_sclk", {31'd0, sclk}, 0);
      check("abort_rgb", {26'd0, rgb_top, rgb_bot}, 0);
      check("abort_done", {31'd0, nl_done}, 0);
      rel = cyc;
      rb  = rise_cnt;
      rst = 1'b0;
      wait_done(base, 400, d);
      check("restart_latency", d - rel, 193);
      check("restart_rises", rise_cnt - rb, 64);
      repeat (10) @(negedge clk);
      check("abort_no_extra_done", done_cnt, base + 1);

      // Back-to-back: begin two cycles after the done pulse
      base = done_cnt;
      run_line(5'd1, 7'd0, t, d);
      n = 0;
      while (cyc < d + 2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      base     = done_cnt;
      nl_begin = 1'b1;
      nl_addr  = 5'd24;
      nl_pwm   = 7'd0;
      t        = cyc;
      check("b2b_gap", t - d, 2);
      ab = addr_cnt;
      @(negedge clk);
      nl_begin = 1'b0;
      wait_done(base, 400, d);
      check("b2b_latency", d - t, 194);
      check("row24_first_addr", {21'd0, addr_log[ab]}, {21'd0, 5'd24, 6'd0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
